// File: rtl/regfile_writeback_arbiter_if.sv
// Writeback bus: ALU and load-unit result handshakes plus the register-file write port.
interface regfile_writeback_arbiter_if;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  logic              aluValid;
  logic              aluReady;
  logic [ADDR_W-1:0] aluAddress;
  logic [DATA_W-1:0] aluData;

  logic              memValid;
  logic              memReady;
  logic [ADDR_W-1:0] memAddress;
  logic [DATA_W-1:0] memData;

  logic              writeEnable;
  logic [ADDR_W-1:0] writeAddress;
  logic [DATA_W-1:0] writeData;

  // Producer / register-file side
  modport master (
    output aluValid, aluAddress, aluData,
    output memValid, memAddress, memData,
    input  aluReady, memReady,
    input  writeEnable, writeAddress, writeData
  );

  // Arbiter side
  modport slave (
    input  aluValid, aluAddress, aluData,
    input  memValid, memAddress, memData,
    output aluReady, memReady,
    output writeEnable, writeAddress, writeData
  );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-port arbiter: ALU results (priority) merged with
// FIFO-buffered load results, x0 writes discarded, load starvation bounded.
// Optional macro WB_LOAD_BYPASS_EN lets a load skip an empty FIFO.
module regfile_writeback_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  regfile_writeback_arbiter_if.slave   bus,
  output logic [$clog2(DEPTH+1)-1:0]   fifoCount
);
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned SC_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            fifo_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [SC_W-1:0]   starve_count;

  logic   empty;
  logic   full;
  logic   forced;
  logic   push;
  logic   pop;
  logic   bypass;
  logic   win;
  entry_t winner;

  // Arbitration: starved FIFO head, then ALU, then FIFO head (or bypassed load)
  always_comb begin
    empty        = (fifoCount == '0);
    full         = (fifoCount == CNT_W'(DEPTH));
    forced       = !empty && (starve_count == SC_W'(STARVE_LIMIT));
    bus.aluReady = !forced;
    bus.memReady = !full;
    pop          = !empty && (forced || !bus.aluValid);
    bypass       = 1'b0;
`ifdef WB_LOAD_BYPASS_EN
    bypass       = empty && bus.memValid && !bus.aluValid;
`endif
    push         = bus.memValid && !full && !bypass;
    win          = 1'b1;
    winner       = fifo_mem[rd_ptr];
    if (pop) begin
      winner = fifo_mem[rd_ptr];
    end else if (bus.aluValid) begin
      winner.address = bus.aluAddress;
      winner.data    = bus.aluData;
    end else if (bypass) begin
      winner.address = bus.memAddress;
      winner.data    = bus.memData;
    end else begin
      win = 1'b0;
    end
  end

  // Load FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fifoCount <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) begin
        fifoCount <= fifoCount + CNT_W'(1);
      end else if (pop && !push) begin
        fifoCount <= fifoCount - CNT_W'(1);
      end
    end
  end

  // Load FIFO storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr].address <= bus.memAddress;
      fifo_mem[wr_ptr].data    <= bus.memData;
    end
  end

  // Cycles a non-empty FIFO has lost arbitration, saturating at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_count <= '0;
    end else if (empty || pop) begin
      starve_count <= '0;
    end else if (starve_count != SC_W'(STARVE_LIMIT)) begin
      starve_count <= starve_count + SC_W'(1);
    end
  end

  // Registered write port; x0 winners are consumed without a strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.writeEnable  <= 1'b0;
      bus.writeAddress <= '0;
      bus.writeData    <= '0;
    end else if (win) begin
      bus.writeEnable  <= (winner.address != '0);
      bus.writeAddress <= winner.address;
      bus.writeData    <= winner.data;
    end else begin
      bus.writeEnable  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter with a per-path write scoreboard.
module tb_regfile_writeback_arbiter;
  logic       clk;
  logic       rst;
  logic [2:0] fifo_count;
  int         checks;
  int         errors;
  logic [36:0] alu_q[$];
  logic [36:0] mem_q[$];

  regfile_writeback_arbiter_if bus ();

  regfile_writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fifoCount (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: check visible writes, then record transfers for the next edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.writeEnable) begin
        if (alu_q.size() != 0 && bus.writeData == alu_q[0][31:0]) begin
          chk("wr_alu", 64'({bus.writeAddress, bus.writeData}), 64'(alu_q[0]));
          void'(alu_q.pop_front());
        end else if (mem_q.size() != 0) begin
          chk("wr_mem_order", 64'({bus.writeAddress, bus.writeData}), 64'(mem_q[0]));
          void'(mem_q.pop_front());
        end else begin
          chk("wr_unexpected", 64'(bus.writeEnable), 64'(0));
        end
      end
      if (bus.aluValid && bus.aluReady && bus.aluAddress != 5'd0)
        alu_q.push_back({bus.aluAddress, bus.aluData});
      if (bus.memValid && bus.memReady && bus.memAddress != 5'd0)
        mem_q.push_back({bus.memAddress, bus.memData});
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.aluValid = 1'b0; bus.aluAddress = 5'd0; bus.aluData = 32'd0;
    bus.memValid = 1'b0; bus.memAddress = 5'd0; bus.memData = 32'd0;

    // Reset state
    #1;
    chk("rst_we",        64'(bus.writeEnable),  64'(0));
    chk("rst_waddr",     64'(bus.writeAddress), 64'(0));
    chk("rst_wdata",     64'(bus.writeData),    64'(0));
    chk("rst_count",     64'(fifo_count),       64'(0));
    chk("rst_alu_ready", 64'(bus.aluReady),     64'(1));
    chk("rst_mem_ready", 64'(bus.memReady),     64'(1));
    step(2);
    rst = 1'b0;

    // ALU write lands one edge after acceptance, then the strobe drops and data holds
    bus.aluValid = 1'b1; bus.aluAddress = 5'd5; bus.aluData = 32'hDEADBEEF;
    #1;
    chk("alu_ready", 64'(bus.aluReady), 64'(1));
    step(1);
    bus.aluValid = 1'b0;
    chk("alu_we",    64'(bus.writeEnable),  64'(1));
    chk("alu_waddr", 64'(bus.writeAddress), 64'(5));
    chk("alu_wdata", 64'(bus.writeData),    64'(32'hDEADBEEF));
    step(1);
    chk("alu_we_drop",    64'(bus.writeEnable),  64'(0));
    chk("alu_addr_hold",  64'(bus.writeAddress), 64'(5));
    chk("alu_data_hold",  64'(bus.writeData),    64'(32'hDEADBEEF));

    // x0 discard on both paths
    bus.aluValid = 1'b1; bus.aluAddress = 5'd0; bus.aluData = 32'h1234;
    bus.memValid = 1'b1; bus.memAddress = 5'd0; bus.memData = 32'h5678;
    #1;
    chk("x0_alu_ready", 64'(bus.aluReady), 64'(1));
    chk("x0_mem_ready", 64'(bus.memReady), 64'(1));
    step(1);
    bus.aluValid = 1'b0; bus.memValid = 1'b0;
    chk("x0_alu_we",    64'(bus.writeEnable), 64'(0));
    chk("x0_alu_wdata", 64'(bus.writeData),   64'(32'h1234));
    chk("x0_pushed",    64'(fifo_count),      64'(1));
    step(1);
    chk("x0_mem_we",    64'(bus.writeEnable), 64'(0));
    chk("x0_popped",    64'(fifo_count),      64'(0));
    step(1);
    chk("x0_idle_we",   64'(bus.writeEnable), 64'(0));

    // FIFO fill under continuous ALU traffic, then forced pops every 4 cycles
    bus.aluValid = 1'b1; bus.aluAddress = 5'd10; bus.aluData = 32'hA1A10000;
    for (int k = 0; k < 4; k++) begin
      bus.memValid = 1'b1; bus.memAddress = 5'(k + 1); bus.memData = 32'hB0000001 + 32'(k);
      #1;
      chk("fill_alu_ready", 64'(bus.aluReady), 64'(1));
      step(1);
    end
    bus.memValid = 1'b0;
    #1;
    chk("fill_full_count", 64'(fifo_count),   64'(4));
    chk("fill_mem_ready",  64'(bus.memReady), 64'(0));
    for (int k = 0; k < 4; k++) begin
      chk("forced_alu_ready", 64'(bus.aluReady), 64'(0));
      chk("forced_count",     64'(fifo_count),   64'(4 - k));
      step(1);
      chk("forced_we",    64'(bus.writeEnable),  64'(1));
      chk("forced_waddr", 64'(bus.writeAddress), 64'(k + 1));
      chk("forced_wdata", 64'(bus.writeData),    64'(32'hB0000001 + 32'(k)));
      if (k == 0) chk("unfull_mem_ready", 64'(bus.memReady), 64'(1));
      for (int j = 0; j < 3; j++) begin
        chk("between_alu_ready", 64'(bus.aluReady), 64'(1));
        step(1);
        chk("between_wdata", 64'(bus.writeData), 64'(32'hA1A10000));
      end
    end
    bus.aluValid = 1'b0;
    chk("drained_count", 64'(fifo_count), 64'(0));

    // Push+pop at count 2 keeps occupancy; 10 loads wrap the pointers in order
    bus.aluAddress = 5'd11; bus.aluData = 32'hA2A20000;
    for (int i = 0; i < 10; i++) begin
      bus.aluValid = (i < 2);
      bus.memValid = 1'b1; bus.memAddress = 5'((i % 31) + 1); bus.memData = 32'hC0000000 + 32'(i);
      step(1);
      chk("wrap_count", 64'(fifo_count), (i == 0) ? 64'(1) : 64'(2));
      if (i >= 2) chk("wrap_order", 64'(bus.writeData), 64'(32'hC0000000 + 32'(i - 2)));
    end
    bus.memValid = 1'b0; bus.aluValid = 1'b0;
    step(2);
    chk("wrap_drained", 64'(fifo_count), 64'(0));

    // Asynchronous reset with three buffered loads
    bus.aluValid = 1'b1; bus.aluAddress = 5'd12; bus.aluData = 32'hA3A30000;
    for (int i = 0; i < 3; i++) begin
      bus.memValid = 1'b1; bus.memAddress = 5'(20 + i); bus.memData = 32'hD0000000 + 32'(i);
      step(1);
    end
    bus.memValid = 1'b0; bus.aluValid = 1'b0;
    chk("pre_rst_count", 64'(fifo_count), 64'(3));
    #2;
    rst = 1'b1;
    alu_q.delete();
    mem_q.delete();
    #1;
    chk("mid_rst_we",        64'(bus.writeEnable), 64'(0));
    chk("mid_rst_count",     64'(fifo_count),      64'(0));
    chk("mid_rst_mem_ready", 64'(bus.memReady),    64'(1));
    step(1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("post_rst_we", 64'(bus.writeEnable), 64'(0));
    end

    // Single load into an empty FIFO with the ALU idle
    bus.memValid = 1'b1; bus.memAddress = 5'd7; bus.memData = 32'hA5A5A5A5;
    step(1);
    bus.memValid = 1'b0;
`ifdef WB_LOAD_BYPASS_EN
    chk("byp_we",    64'(bus.writeEnable),  64'(1));
    chk("byp_waddr", 64'(bus.writeAddress), 64'(7));
    chk("byp_wdata", 64'(bus.writeData),    64'(32'hA5A5A5A5));
    chk("byp_count", 64'(fifo_count),       64'(0));
`else
    chk("load_early_we", 64'(bus.writeEnable), 64'(0));
    chk("load_count",    64'(fifo_count),      64'(1));
    step(1);
    chk("load_we",    64'(bus.writeEnable),  64'(1));
    chk("load_waddr", 64'(bus.writeAddress), 64'(7));
    chk("load_wdata", 64'(bus.writeData),    64'(32'hA5A5A5A5));
    chk("load_count_after", 64'(fifo_count), 64'(0));
`endif

    step(3);
    chk("alu_queue_drained", 64'(alu_q.size()), 64'(0));
    chk("mem_queue_drained", 64'(mem_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
